spi_slave_port: RTL

- SPI slave (peripheral) endpoint with an Avalon-MM register interface. It is the far end of the system's SPI master link.
- Mode is fixed at CPOL=1, CPHA=1, MSB first, one slave select. SCLK idles high, data is driven on the falling edge and sampled on the rising edge.
- The SPI pins are oversampled in the clk domain. The CPU sees rx/tx holding registers, status and control registers, and an irq line.

---
 rtl/spi_pkg.sv | 38 +++
 rtl/spi_pin_sync.sv | 52 +++++
 rtl/spi_slave_port.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave port: register map, flag bit positions, frame FSM states.
package spi_pkg;

    localparam int unsigned REG_W  = 16;
    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_RXDATA  = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_TXDATA  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CONTROL = 3'd3;

    localparam int unsigned BIT_ROE  = 3;
    localparam int unsigned BIT_TOE  = 4;
    localparam int unsigned BIT_TMT  = 5;
    localparam int unsigned BIT_TRDY = 6;
    localparam int unsigned BIT_RRDY = 7;
    localparam int unsigned BIT_E    = 8;

    localparam int unsigned BIT_IROE  = 3;
    localparam int unsigned BIT_ITOE  = 4;
    localparam int unsigned BIT_ITRDY = 6;
    localparam int unsigned BIT_IRRDY = 7;
    localparam int unsigned BIT_IE    = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } frame_state_e;

    typedef struct packed {
        logic ie;
        logic irrdy;
        logic itrdy;
        logic itoe;
        logic iroe;
    } spi_ctrl_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage pin synchronizer with optional edge detection on the synchronized level.
module spi_pin_sync #(
    parameter int unsigned STAGES      = 2,
    parameter bit          EDGE_DETECT = 1'b1,
    parameter logic        RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= STAGES'({sync_q, din});
        end
    end

    assign dout = sync_q[STAGES-1];

    if (EDGE_DETECT) begin : g_edge
        localparam int unsigned VLD_W = STAGES + 1;

        logic             hist_q;
        logic [VLD_W-1:0] vld_q;

        // Edges are only reported once the pipeline holds real pin samples, so a
        // pin already low when reset releases does not look like a fresh edge.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                hist_q <= RESET_VAL;
                vld_q  <= '0;
            end else begin
                hist_q <= dout;
                vld_q  <= VLD_W'({vld_q, 1'b1});
            end
        end

        assign rise_c = vld_q[VLD_W-1] &  dout & ~hist_q;
        assign fall_c = vld_q[VLD_W-1] & ~dout &  hist_q;
    end else begin : g_level_only
        assign rise_c = 1'b0;
        assign fall_c = 1'b0;
    end

endmodule

// File: rtl/spi_slave_port.sv
// SPI slave endpoint (CPOL=1, CPHA=1, MSB first) with an Avalon-MM register interface.
module spi_slave_port #(
    parameter int unsigned          DATABITS    = 8,
    parameter logic [DATABITS-1:0]  FILL        = DATABITS'(8'hFF),
    parameter int unsigned          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic [2:0]  mem_addr,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    input  logic        read_n,
    input  logic        write_n,
    input  logic        spi_select,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata
);
    import spi_pkg::*;

    localparam int unsigned CNT_W = $clog2(DATABITS);
    localparam int unsigned SH_W  = DATABITS - 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATABITS - 1);

    logic sclk_rise_c, sclk_fall_c, ss_rise_c, ss_fall_c, mosi_s;
    logic unused_sclk_lvl, unused_ss_lvl, unused_mosi_rise, unused_mosi_fall, unused_wdata;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .EDGE_DETECT(1'b1), .RESET_VAL(1'b1)) u_sclk_sync (
        .clk(clk), .reset_n(reset_n), .din(SCLK),
        .dout(unused_sclk_lvl), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .EDGE_DETECT(1'b1), .RESET_VAL(1'b1)) u_ss_sync (
        .clk(clk), .reset_n(reset_n), .din(SS_n),
        .dout(unused_ss_lvl), .rise_c(ss_rise_c), .fall_c(ss_fall_c)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .EDGE_DETECT(1'b0), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .reset_n(reset_n), .din(MOSI),
        .dout(mosi_s), .rise_c(unused_mosi_rise), .fall_c(unused_mosi_fall)
    );

    frame_state_e       state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [SH_W-1:0]    rx_shift_q;
    logic [DATABITS-1:0] rx_holding_q, tx_shift_q, tx_holding_q;
    logic               trdy_q, rrdy_q, roe_q, toe_q, miso_oe_q, irq_q;
    spi_ctrl_t          ctrl_q;
    logic               rd_strobe_q, wr_strobe_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [REG_W-1:0]   wdata_q, data_to_cpu_q, status_c, ctrl_rd_c, rd_data_c;

    logic frame_start_c, byte_done_c, rx_shift_en_c, tx_shift_en_c, tx_load_c;
    logic rd_p1_c, wr_p1_c, rx_rd_c, tx_wr_c, status_wr_c, ctrl_wr_c, tx_accept_c;
    logic tmt_c, irq_c;

    assign unused_wdata = ^wdata_q;

    // Host access: strobe registered in cycle 1, side effects applied in cycle 2.
    assign rd_p1_c     = ~rd_strobe_q & spi_select & ~read_n;
    assign wr_p1_c     = ~wr_strobe_q & spi_select & ~write_n;
    assign rx_rd_c     = rd_strobe_q & (addr_q == ADDR_RXDATA);
    assign tx_wr_c     = wr_strobe_q & (addr_q == ADDR_TXDATA);
    assign status_wr_c = wr_strobe_q & (addr_q == ADDR_STATUS);
    assign ctrl_wr_c   = wr_strobe_q & (addr_q == ADDR_CONTROL);
    // A write coinciding with a shift-register reload is accepted: the reload takes the old holding value.
    assign tx_accept_c = tx_wr_c & (trdy_q | tx_load_c);
    assign tx_load_c   = frame_start_c | byte_done_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        frame_start_c = 1'b0;
        byte_done_c   = 1'b0;
        rx_shift_en_c = 1'b0;
        tx_shift_en_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ss_fall_c) begin
                    state_d       = ST_ACTIVE;
                    frame_start_c = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise_c) begin
                    state_d = ST_IDLE;
                end else begin
                    rx_shift_en_c = sclk_rise_c;
                    byte_done_c   = sclk_rise_c & (bit_cnt_q == LAST_BIT);
                    tx_shift_en_c = sclk_fall_c & (bit_cnt_q != '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tmt_c = ~((state_q == ST_ACTIVE) & (bit_cnt_q != '0)) & trdy_q;
    assign irq_c = (roe_q & ctrl_q.iroe) | (toe_q & ctrl_q.itoe) | (trdy_q & ctrl_q.itrdy)
                 | (rrdy_q & ctrl_q.irrdy) | ((roe_q | toe_q) & ctrl_q.ie);

    always_comb begin
        status_c            = '0;
        status_c[BIT_ROE]   = roe_q;
        status_c[BIT_TOE]   = toe_q;
        status_c[BIT_TMT]   = tmt_c;
        status_c[BIT_TRDY]  = trdy_q;
        status_c[BIT_RRDY]  = rrdy_q;
        status_c[BIT_E]     = roe_q | toe_q;
        ctrl_rd_c            = '0;
        ctrl_rd_c[BIT_IROE]  = ctrl_q.iroe;
        ctrl_rd_c[BIT_ITOE]  = ctrl_q.itoe;
        ctrl_rd_c[BIT_ITRDY] = ctrl_q.itrdy;
        ctrl_rd_c[BIT_IRRDY] = ctrl_q.irrdy;
        ctrl_rd_c[BIT_IE]    = ctrl_q.ie;
        rd_data_c            = '0;
        case (mem_addr)
            ADDR_RXDATA:  rd_data_c = REG_W'(rx_holding_q);
            ADDR_STATUS:  rd_data_c = status_c;
            ADDR_CONTROL: rd_data_c = ctrl_rd_c;
            default:      rd_data_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            rx_holding_q  <= '0;
            tx_shift_q    <= FILL;
            tx_holding_q  <= '0;
            trdy_q        <= 1'b1;
            rrdy_q        <= 1'b0;
            roe_q         <= 1'b0;
            toe_q         <= 1'b0;
            ctrl_q        <= '0;
            miso_oe_q     <= 1'b0;
            irq_q         <= 1'b0;
            rd_strobe_q   <= 1'b0;
            wr_strobe_q   <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            data_to_cpu_q <= '0;
        end else begin
            rd_strobe_q <= rd_p1_c;
            wr_strobe_q <= wr_p1_c;
            if (rd_p1_c | wr_p1_c) addr_q <= mem_addr;
            if (wr_p1_c) wdata_q <= data_from_cpu;
            if (rd_p1_c) data_to_cpu_q <= rd_data_c;

            if (frame_start_c) begin
                bit_cnt_q <= '0;
            end else if (rx_shift_en_c) begin
                bit_cnt_q <= byte_done_c ? '0 : bit_cnt_q + CNT_W'(1);
            end
            if (rx_shift_en_c) rx_shift_q <= SH_W'({rx_shift_q, mosi_s});
            if (byte_done_c) rx_holding_q <= {rx_shift_q, mosi_s};

            if (tx_load_c) begin
                tx_shift_q <= trdy_q ? FILL : tx_holding_q;
            end else if (tx_shift_en_c) begin
                tx_shift_q <= {tx_shift_q[DATABITS-2:0], 1'b1};
            end

            if (tx_accept_c) begin
                tx_holding_q <= wdata_q[DATABITS-1:0];
                trdy_q       <= 1'b0;
            end else if (tx_load_c) begin
                trdy_q <= 1'b1;
            end

            if (tx_wr_c & ~tx_accept_c) begin
                toe_q <= 1'b1;
            end else if (status_wr_c) begin
                toe_q <= 1'b0;
            end

            // Byte completion outranks both an rx read and a status-write clear.
            if (byte_done_c) begin
                rrdy_q <= 1'b1;
            end else if (rx_rd_c | status_wr_c) begin
                rrdy_q <= 1'b0;
            end
            if (byte_done_c & rrdy_q & ~rx_rd_c) begin
                roe_q <= 1'b1;
            end else if (status_wr_c) begin
                roe_q <= 1'b0;
            end

            if (ctrl_wr_c) begin
                ctrl_q.iroe  <= wdata_q[BIT_IROE];
                ctrl_q.itoe  <= wdata_q[BIT_ITOE];
                ctrl_q.itrdy <= wdata_q[BIT_ITRDY];
                ctrl_q.irrdy <= wdata_q[BIT_IRRDY];
                ctrl_q.ie    <= wdata_q[BIT_IE];
            end

            miso_oe_q <= (state_d == ST_ACTIVE);
            irq_q     <= irq_c;
        end
    end

    assign MISO          = tx_shift_q[DATABITS-1];
    assign MISO_oe       = miso_oe_q;
    assign data_to_cpu   = data_to_cpu_q;
    assign irq           = irq_q;
    assign dataavailable = rrdy_q;
    assign readyfordata  = trdy_q;

endmodule
